// File: rtl/memory_control.sv
// memory_control: memory-side responder for the cache bus.
//   Arbitrates icache reads and dcache reads/writes onto one single-ported,
//   variable-latency RAM. The dcache has priority. The icache is forced through
//   after STARVE_LIM consecutive d-grants made while it was waiting.
//   FSM: IDLE -> ACCESS -> RESP -> IDLE. All outputs are registered.
// Ports:
//   CLK, RST               clock (rising edge), synchronous active-high reset
//   iREN, iaddr            icache read request and address
//   dREN, dWEN, daddr,     dcache read/write request, address, write data
//   dstore
//   iwait, dwait           low for one cycle when the request completes
//   iload, dload           read data, valid while the matching wait is low
//   ramREN, ramWEN,        RAM strobes, address and write data
//   ramaddr, ramstore
//   ramload, ramwait       RAM read data; ramwait=0 means the access is done
// Optional feature, enabled by defining MEMCTL_STATS_EN:
//   icount, dcount         completed i/d accesses (32-bit, wrapping)
//   stallcnt               cycles spent in ACCESS with ramwait=1 (32-bit, wrapping)
module memory_control #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              iwait,
  output logic              dwait,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
`ifdef MEMCTL_STATS_EN
  output logic [31:0]       icount,
  output logic [31:0]       dcount,
  output logic [31:0]       stallcnt,
`endif
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramwait
);

  localparam int unsigned SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic              gnt_d_q, gnt_d_d;   // 1 = dcache holds the grant
  logic              wr_q, wr_d;         // latched access type
  logic [SW-1:0]     starve_q, starve_d;
  logic              iwait_q, iwait_d;
  logic              dwait_q, dwait_d;
  logic [DATA_W-1:0] iload_q, iload_d;
  logic [DATA_W-1:0] dload_q, dload_d;
  logic              ramREN_q, ramREN_d;
  logic              ramWEN_q, ramWEN_d;
  logic [ADDR_W-1:0] ramaddr_q, ramaddr_d;
  logic [DATA_W-1:0] ramstore_q, ramstore_d;
`ifdef MEMCTL_STATS_EN
  logic [31:0]       icount_q, icount_d;
  logic [31:0]       dcount_q, dcount_d;
  logic [31:0]       stall_q, stall_d;
`endif

  logic d_req, grant_d, grant_i, withdraw;

  assign d_req    = dREN | dWEN;
  // The icache is forced through only when it is waiting and the limit is reached.
  assign grant_d  = d_req && !(iREN && (starve_q == LIM));
  assign grant_i  = !grant_d && iREN;
  assign withdraw = gnt_d_q ? !d_req : !iREN;

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      gnt_d_q    <= 1'b0;
      wr_q       <= 1'b0;
      starve_q   <= '0;
      iwait_q    <= 1'b1;
      dwait_q    <= 1'b1;
      iload_q    <= '0;
      dload_q    <= '0;
      ramREN_q   <= 1'b0;
      ramWEN_q   <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
`ifdef MEMCTL_STATS_EN
      icount_q   <= '0;
      dcount_q   <= '0;
      stall_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_d_q    <= gnt_d_d;
      wr_q       <= wr_d;
      starve_q   <= starve_d;
      iwait_q    <= iwait_d;
      dwait_q    <= dwait_d;
      iload_q    <= iload_d;
      dload_q    <= dload_d;
      ramREN_q   <= ramREN_d;
      ramWEN_q   <= ramWEN_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
`ifdef MEMCTL_STATS_EN
      icount_q   <= icount_d;
      dcount_q   <= dcount_d;
      stall_q    <= stall_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_d || grant_i) state_d = ACCESS;
      ACCESS: begin
        // Withdrawal wins over a completion arriving in the same cycle.
        if (withdraw)      state_d = IDLE;
        else if (!ramwait) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    gnt_d_d    = gnt_d_q;
    wr_d       = wr_q;
    starve_d   = starve_q;
    iwait_d    = 1'b1;
    dwait_d    = 1'b1;
    iload_d    = iload_q;
    dload_d    = dload_q;
    ramREN_d   = ramREN_q;
    ramWEN_d   = ramWEN_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
`ifdef MEMCTL_STATS_EN
    icount_d   = icount_q;
    dcount_d   = dcount_q;
    stall_d    = stall_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          gnt_d_d    = 1'b1;
          wr_d       = dWEN;             // dREN together with dWEN counts as a write
          ramREN_d   = !dWEN;
          ramWEN_d   = dWEN;
          ramaddr_d  = daddr;
          ramstore_d = dstore;
          if (!iREN)                starve_d = '0;
          else if (starve_q != LIM) starve_d = starve_q + 1'b1;
        end else if (grant_i) begin
          gnt_d_d   = 1'b0;
          wr_d      = 1'b0;
          ramREN_d  = 1'b1;
          ramWEN_d  = 1'b0;
          ramaddr_d = iaddr;
          starve_d  = '0;
        end
      end
      ACCESS: begin
`ifdef MEMCTL_STATS_EN
        if (ramwait) stall_d = stall_q + 32'd1;
`endif
        if (withdraw) begin
          ramREN_d = 1'b0;
          ramWEN_d = 1'b0;
        end else if (!ramwait) begin
          ramREN_d = 1'b0;
          ramWEN_d = 1'b0;
          if (gnt_d_q) begin
            dwait_d = 1'b0;
            if (!wr_q) dload_d = ramload;
`ifdef MEMCTL_STATS_EN
            dcount_d = dcount_q + 32'd1;
`endif
          end else begin
            iwait_d = 1'b0;
            iload_d = ramload;
`ifdef MEMCTL_STATS_EN
            icount_d = icount_q + 32'd1;
`endif
          end
        end
      end
      default: ;
    endcase
  end

  assign iwait    = iwait_q;
  assign dwait    = dwait_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ramREN   = ramREN_q;
  assign ramWEN   = ramWEN_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
`ifdef MEMCTL_STATS_EN
  assign icount   = icount_q;
  assign dcount   = dcount_q;
  assign stallcnt = stall_q;
`endif

endmodule

// File: tb/tb_memory_control.sv
module tb_memory_control;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload;
  logic        ramwait;
`ifdef MEMCTL_STATS_EN
  logic [31:0] icount, dcount, stallcnt;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  memory_control #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
`ifdef MEMCTL_STATS_EN
    .icount(icount), .dcount(dcount), .stallcnt(stallcnt),
`endif
    .ramload(ramload), .ramwait(ramwait)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

`ifdef MEMCTL_STATS_EN
  // One access with exactly two ramwait=1 cycles in ACCESS.
  task automatic xfer2(input logic is_i, input logic wr, input logic [31:0] addr);
    ramwait = 1'b1;
    if (is_i) begin iREN = 1'b1; iaddr = addr; end
    else begin dREN = !wr; dWEN = wr; daddr = addr; dstore = addr ^ 32'hA5A5_A5A5; end
    step();   // granted
    step();   // first stall
    step();   // second stall
    ramwait = 1'b0;
    step();   // RESP
    check(is_i ? "stat_iwait" : "stat_dwait", is_i ? 32'(iwait) : 32'(dwait), 32'd0);
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    string       exp_s;
    int unsigned ngrant;
    logic [31:0] gch;

    RST = 1'b1; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramwait = 1'b0;

    // Reset held two cycles with a pending icache request
    for (int k = 0; k < 2; k++) begin
      step();
      check("rst_iwait", 32'(iwait), 32'd1);
      check("rst_dwait", 32'(dwait), 32'd1);
      check("rst_ramREN", 32'(ramREN), 32'd0);
      check("rst_iload", iload, 32'd0);
    end
    check("rst_dload", dload, 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    RST = 1'b0; iREN = 1'b0;
    step();

    // Single icache read, zero latency
    iREN = 1'b1; iaddr = 32'h40; ramload = 32'hDEAD_BEEF; ramwait = 1'b0;
    step();
    check("rd_ramREN", 32'(ramREN), 32'd1);
    check("rd_ramaddr", ramaddr, 32'h40);
    check("rd_iwait_c2", 32'(iwait), 32'd1);
    step();
    check("rd_iwait_c3", 32'(iwait), 32'd0);
    check("rd_iload", iload, 32'hDEAD_BEEF);
    check("rd_ramREN_off", 32'(ramREN), 32'd0);
    check("rd_dwait", 32'(dwait), 32'd1);
    iREN = 1'b0;
    step();
    check("rd_iwait_c4", 32'(iwait), 32'd1);
    check("rd_iload_hold", iload, 32'hDEAD_BEEF);

    // dcache read
    dREN = 1'b1; daddr = 32'h80; ramload = 32'hCAFE_F00D;
    step();
    check("drd_ramaddr", ramaddr, 32'h80);
    step();
    check("drd_dwait", 32'(dwait), 32'd0);
    check("drd_dload", dload, 32'hCAFE_F00D);
    check("drd_iwait", 32'(iwait), 32'd1);
    dREN = 1'b0;
    step();
    check("drd_dwait_off", 32'(dwait), 32'd1);

    // dcache write, ramwait high for 5 cycles
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'h1234; ramload = 32'h5555_5555; ramwait = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("wr_ramWEN", 32'(ramWEN), 32'd1);
      check("wr_dwait_busy", 32'(dwait), 32'd1);
    end
    check("wr_ramREN", 32'(ramREN), 32'd0);
    check("wr_ramaddr", ramaddr, 32'h100);
    check("wr_ramstore", ramstore, 32'h1234);
    ramwait = 1'b0;
    step();
    check("wr_ramWEN_off", 32'(ramWEN), 32'd0);
    check("wr_dwait", 32'(dwait), 32'd0);
    check("wr_dload", dload, 32'hCAFE_F00D);
    dWEN = 1'b0;
    step();
    check("wr_dwait_once", 32'(dwait), 32'd1);

    // Withdrawal during ACCESS
    dREN = 1'b1; daddr = 32'h200; ramwait = 1'b1;
    step();
    check("wd_ramREN", 32'(ramREN), 32'd1);
    step();
    check("wd_ramREN_hold", 32'(ramREN), 32'd1);
    dREN = 1'b0;
    step();
    check("wd_ramREN_off", 32'(ramREN), 32'd0);
    check("wd_dwait", 32'(dwait), 32'd1);
    step();
    check("wd_dwait_idle", 32'(dwait), 32'd1);
    check("wd_ramREN_idle", 32'(ramREN), 32'd0);
    ramwait = 1'b0;

    // Priority and starvation with both requests held
    exp_s = "ddddiddddi";
    iREN = 1'b1; iaddr = 32'h1000; dREN = 1'b1; daddr = 32'h2000;
    ngrant = 0;
    for (int k = 0; k < 60 && ngrant < 10; k++) begin
      step();
      if (ramREN) begin
        gch = (ramaddr == 32'h2000) ? 32'("d") : 32'("i");
        check("grant_order", gch, 32'(exp_s[ngrant]));
        ngrant++;
      end
    end
    check("grant_count", ngrant, 32'd10);
    iREN = 1'b0; dREN = 1'b0;
    repeat (3) step();

`ifdef MEMCTL_STATS_EN
    begin
      logic [31:0] c0, s0;
      c0 = icount + dcount;
      s0 = stallcnt;
      xfer2(1'b1, 1'b0, 32'h300);
      xfer2(1'b0, 1'b0, 32'h304);
      xfer2(1'b1, 1'b0, 32'h308);
      xfer2(1'b0, 1'b1, 32'h30C);
      xfer2(1'b0, 1'b1, 32'h310);
      check("stat_count", icount + dcount - c0, 32'd5);
      check("stat_stall", stallcnt - s0, 32'd10);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
